demux: RTL and testbench

DEMUX -- requirements
Module: demux

---
 rtl/demux.sv | 132 +++++++++++++
 tb/tb_demux.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/demux.sv
// demux: routes one input stream to three independent FIFO channels.
// Select priority is sel1 > sel2 > sel3; unrouted offers are counted.
module demux #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] ip,
  input  logic             ip_valid,
  output logic             ip_ready,
  input  logic             sel1,
  input  logic             sel2,
  input  logic             sel3,
  output logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] op3,
  output logic             op1_valid,
  output logic             op2_valid,
  output logic             op3_valid,
  input  logic             op1_ready,
  input  logic             op2_ready,
  input  logic             op3_ready,
  output logic [7:0]       drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [3][DEPTH];
  logic [WIDTH-1:0] mem_d [3][DEPTH];
  logic [AW-1:0]    wr_q  [3];
  logic [AW-1:0]    wr_d  [3];
  logic [AW-1:0]    rd_q  [3];
  logic [AW-1:0]    rd_d  [3];
  logic [CW-1:0]    cnt_q [3];
  logic [CW-1:0]    cnt_d [3];
  logic [2:0]       full_q;
  logic [2:0]       full_d;
  logic [7:0]       drop_q;
  logic [7:0]       drop_d;

  logic [2:0] sel_oh;
  logic [2:0] push;
  logic [2:0] pop;
  logic [2:0] vld;
  logic [2:0] rdy;

  always_comb begin
    sel_oh = 3'b000;
    if (sel1) begin
      sel_oh = 3'b001;
    end else if (sel2) begin
      sel_oh = 3'b010;
    end else if (sel3) begin
      sel_oh = 3'b100;
    end
  end

  // Acceptance looks only at registered full flags, so a same-cycle
  // pop never opens room for a push.
  assign ip_ready = !reset && (|(sel_oh & ~full_q));
  assign push     = {3{ip_valid && ip_ready}} & sel_oh;
  assign rdy      = {op3_ready, op2_ready, op1_ready};

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      vld[c] = !reset && (cnt_q[c] != '0);
    end
  end

  assign pop = vld & rdy;

  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    drop_d = drop_q;
    for (int c = 0; c < 3; c++) begin
      if (push[c]) begin
        mem_d[c][wr_q[c]] = ip;
        wr_d[c]           = wr_q[c] + 1'b1;
      end
      if (pop[c]) begin
        rd_d[c] = rd_q[c] + 1'b1;
      end
      unique case ({push[c], pop[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
        2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
        default: cnt_d[c] = cnt_q[c];
      endcase
      full_d[c] = (cnt_d[c] == FULL_CNT);
    end
    if (ip_valid && (sel_oh == 3'b000) && (drop_q != 8'hff)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < 3; c++) begin
        for (int e = 0; e < DEPTH; e++) begin
          mem_q[c][e] <= '0;
        end
        wr_q[c]  <= '0;
        rd_q[c]  <= '0;
        cnt_q[c] <= '0;
      end
      full_q <= '0;
      drop_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
      drop_q <= drop_d;
    end
  end

  assign op1       = mem_q[0][rd_q[0]];
  assign op2       = mem_q[1][rd_q[1]];
  assign op3       = mem_q[2][rd_q[2]];
  assign op1_valid = vld[0];
  assign op2_valid = vld[1];
  assign op3_valid = vld[2];
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_demux.sv
// tb_demux: directed and random traffic through demux with a
// per-channel reference queue checked every cycle at the falling edge.
module tb_demux;
  localparam int W = 4;
  localparam int D = 2;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] ip;
  logic         ip_valid;
  logic         ip_ready;
  logic         sel1, sel2, sel3;
  logic [W-1:0] op1, op2, op3;
  logic         op1_valid, op2_valid, op3_valid;
  logic         op1_ready, op2_ready, op3_ready;
  logic [7:0]   drop_cnt;

  demux #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .reset(reset),
    .ip(ip), .ip_valid(ip_valid), .ip_ready(ip_ready),
    .sel1(sel1), .sel2(sel2), .sel3(sel3),
    .op1(op1), .op2(op2), .op3(op3),
    .op1_valid(op1_valid), .op2_valid(op2_valid),
    .op3_valid(op3_valid),
    .op1_ready(op1_ready), .op2_ready(op2_ready),
    .op3_ready(op3_ready),
    .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q [3][$];
  int           drop_m;
  int           ch;
  logic [2:0]   ov;
  logic [2:0]   ordy;
  logic [W-1:0] od [3];

  assign ov    = {op3_valid, op2_valid, op1_valid};
  assign ordy  = {op3_ready, op2_ready, op1_ready};
  assign od[0] = op1;
  assign od[1] = op2;
  assign od[2] = op3;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: ready uses occupancy before this edge's pop.
  always @(negedge clock) begin
    if (reset) begin
      chk("ip_ready_in_reset", {31'd0, ip_ready}, 32'd0);
      chk("valid_in_reset", {29'd0, ov}, 32'd0);
      for (int c = 0; c < 3; c++) exp_q[c].delete();
      drop_m = 0;
    end else begin
      ch = sel1 ? 0 : sel2 ? 1 : sel3 ? 2 : -1;
      if (ch < 0)
        chk("ip_ready_nosel", {31'd0, ip_ready}, 32'd0);
      else
        chk("ip_ready", {31'd0, ip_ready},
            {31'd0, exp_q[ch].size() < D});
      chk("drop_cnt", {24'd0, drop_cnt}, drop_m);
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("op%0d_valid", c + 1), {31'd0, ov[c]},
            {31'd0, exp_q[c].size() != 0});
        if (ov[c] && exp_q[c].size() != 0)
          chk($sformatf("op%0d_data", c + 1), {28'd0, od[c]},
              {28'd0, exp_q[c][0]});
      end
      for (int c = 0; c < 3; c++) begin
        if (ov[c] && ordy[c]) begin
          if (exp_q[c].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL pop_empty: ch %0d popped while empty", c + 1);
          end else begin
            void'(exp_q[c].pop_front());
          end
        end
      end
      if (ip_valid && ip_ready) begin
        n_tests++;
        if (ch < 0 || exp_q[ch].size() >= D) begin
          n_fail++;
          $display("FAIL write_full: accepted with ch %0d, expected none",
                   ch + 1);
        end else begin
          exp_q[ch].push_back(ip);
        end
      end
      if (ip_valid && ch < 0 && drop_m < 255) drop_m++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ip_valid = 0; sel1 = 0; sel2 = 0; sel3 = 0;
  endtask

  initial begin
    bit got;
    reset = 1; ip = '0; ip_valid = 0;
    sel1 = 0; sel2 = 0; sel3 = 0;
    op1_ready = 0; op2_ready = 0; op3_ready = 0;
    tick(); tick();
    reset = 0;
    chk("rst_op1", {28'd0, op1}, 32'd0);
    chk("rst_op2", {28'd0, op2}, 32'd0);
    chk("rst_op3", {28'd0, op3}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);

    // priority
    sel1 = 1; sel2 = 1; sel3 = 1; ip = 4'hA; ip_valid = 1;
    tick();
    idle();
    chk("prio_op1", {28'd0, op1}, 32'hA);
    chk("prio_v1", {31'd0, op1_valid}, 32'd1);
    chk("prio_v23", {30'd0, op3_valid, op2_valid}, 32'd0);
    op1_ready = 1; tick(); op1_ready = 0;

    // fill and back-pressure on channel 2
    sel2 = 1; ip_valid = 1;
    ip = 4'h1; tick();
    ip = 4'h2; tick();
    ip = 4'h3;
    chk("bp_full", {31'd0, ip_ready}, 32'd0);
    tick();
    chk("bp_full_hold", {31'd0, ip_ready}, 32'd0);
    chk("bp_head", {28'd0, op2}, 32'h1);
    op2_ready = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (ip_ready) got = 1;
      tick();
    end
    chk("bp_accept3", {31'd0, got}, 32'd1);
    idle();
    repeat (4) tick();
    op2_ready = 0;

    // simultaneous push and pop on channel 3
    sel3 = 1; ip = 4'h5; ip_valid = 1; tick();
    ip = 4'h7; op3_ready = 1; tick();
    idle(); op3_ready = 0;
    chk("pp_op3", {28'd0, op3}, 32'h7);
    chk("pp_v3", {31'd0, op3_valid}, 32'd1);
    op3_ready = 1; tick(); op3_ready = 0;
    chk("pp_empty", {31'd0, op3_valid}, 32'd0);

    // no select: drop counter saturates
    ip = 4'h9; ip_valid = 1;
    repeat (300) tick();
    idle();
    chk("drop_sat", {24'd0, drop_cnt}, 32'd255);

    // reset mid-operation
    sel1 = 1; ip_valid = 1; ip = 4'hB; tick();
    ip = 4'hC; tick();
    sel1 = 0; sel2 = 1; ip = 4'hD; tick();
    idle();
    reset = 1; tick(); reset = 0;
    chk("mid_rst_valid", {29'd0, ov}, 32'd0);
    chk("mid_rst_drop", {24'd0, drop_cnt}, 32'd0);
    sel1 = 1; ip = 4'hE; ip_valid = 1; tick();
    idle();
    chk("post_rst_op1", {28'd0, op1}, 32'hE);
    chk("post_rst_v1", {31'd0, op1_valid}, 32'd1);
    chk("post_rst_v2", {31'd0, op2_valid}, 32'd0);
    op1_ready = 1; tick(); op1_ready = 0;
    chk("post_rst_drain", {31'd0, op1_valid}, 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      {sel3, sel2, sel1} = 3'($urandom_range(0, 7));
      ip       = 4'($urandom);
      ip_valid = 1'($urandom);
      op1_ready = 1'($urandom);
      op2_ready = 1'($urandom);
      op3_ready = 1'($urandom);
      tick();
    end
    idle();
    op1_ready = 1; op2_ready = 1; op3_ready = 1;
    repeat (6) tick();
    chk("final_empty", {29'd0, ov}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
